// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Each accepted step sweeps every neuron once, then reports the spike vector with a done pulse.
module lif_array #(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REFRACT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [N_NEURONS*WIDTH-1:0]   current,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [2:0]                   beta,
    input  logic                         reset_mode,
    input  logic [$clog2(N_NEURONS)-1:0] sel,
    output logic                         busy,
    output logic                         done,
    output logic [N_NEURONS-1:0]         spike,
    output logic [WIDTH-1:0]             state_out
);

    localparam int unsigned IW    = $clog2(N_NEURONS);
    localparam int unsigned CW    = $clog2(N_NEURONS + 1);
    localparam int unsigned RW    = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int unsigned Slots = 1 << IW;

    // The index runs one past the last neuron: that drain cycle hands the full
    // pending vector to spike on the edge that enters DONE.
    localparam logic [CW-1:0] DrainIdx = CW'(N_NEURONS);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic                   accept;
    logic                   write_en;
    logic                   drain;

    logic [N_NEURONS*WIDTH-1:0] cur_q;
    logic [WIDTH-1:0]       thr_q;
    logic [2:0]             beta_q;
    logic                   mode_q;

    logic [WIDTH-1:0]       mem_q [Slots];
    logic [RW-1:0]          ref_q [Slots];
    logic [Slots-1:0]       pend_q;

    logic [IW-1:0]          cur_idx;
    logic [WIDTH-1:0]       v;
    logic [RW-1:0]          rc;
    logic [WIDTH-1:0]       cin;
    logic [WIDTH-1:0]       leaked;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       sat;
    logic [WIDTH-1:0]       v_new;
    logic [RW-1:0]          rc_new;
    logic                   fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = StSweep;
                end
            end
            StSweep: begin
                if (idx_q == DrainIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign write_en = (state_q == StSweep) && (idx_q != DrainIdx);
    assign drain    = (state_q == StSweep) && (idx_q == DrainIdx);
    assign cur_idx  = idx_q[IW-1:0];

    always_comb begin
        v      = mem_q[cur_idx];
        rc     = ref_q[cur_idx];
        cin    = cur_q[cur_idx*WIDTH +: WIDTH];
        leaked = (beta_q == 3'd0) ? v : v - (v >> beta_q);
        sum    = {1'b0, leaked} + {1'b0, cin};
        sat    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        v_new  = v;
        rc_new = '0;
        fire   = 1'b0;
        if (rc != '0) begin
            rc_new = rc - 1'b1;
        end else if (sat >= thr_q) begin
            fire   = 1'b1;
            rc_new = RW'(REFRACT);
            v_new  = mode_q ? (sat - thr_q) : '0;
        end else begin
            v_new = sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Slots; i++) begin
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
            pend_q    <= '0;
            spike     <= '0;
            state_out <= '0;
            cur_q     <= '0;
            thr_q     <= '0;
            beta_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            if (accept) begin
                cur_q  <= current;
                thr_q  <= threshold;
                beta_q <= beta;
                mode_q <= reset_mode;
                pend_q <= '0;
            end
            if (write_en) begin
                mem_q[cur_idx]  <= v_new;
                ref_q[cur_idx]  <= rc_new;
                pend_q[cur_idx] <= fire;
            end
            if (drain) begin
                spike <= pend_q[N_NEURONS-1:0];
            end
            state_out <= mem_q[sel];
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// Randomised and directed checks of lif_array against a timestep-level behavioural model.
module tb_lif_array;

    localparam int N = 4;
    localparam int W = 8;
    localparam int R = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           step = 1'b0;
    logic [N*W-1:0] current = '0;
    logic [W-1:0]   threshold = '0;
    logic [2:0]     beta = '0;
    logic           reset_mode = 1'b0;
    logic [1:0]     sel = '0;
    logic           busy;
    logic           done;
    logic [N-1:0]   spike;
    logic [W-1:0]   state_out;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state: one timestep at a time.
    int m [N];
    int r [N];
    int mspk;

    always #5 clk = ~clk;

    lif_array #(.N_NEURONS(N), .WIDTH(W), .REFRACT(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .current    (current),
        .threshold  (threshold),
        .beta       (beta),
        .reset_mode (reset_mode),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .spike      (spike),
        .state_out  (state_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m[i] = 0;
            r[i] = 0;
        end
        mspk = 0;
    endtask

    task automatic model_step(input logic [31:0] cur, input int thr, input int b, input int mode);
        int c, lk, s;
        mspk = 0;
        for (int i = 0; i < N; i++) begin
            c = int'((cur >> (8 * i)) & 32'hff);
            if (r[i] != 0) begin
                r[i] = r[i] - 1;
            end else begin
                lk = (b == 0) ? m[i] : m[i] - m[i] / (2 ** b);
                s  = lk + c;
                if (s > 255) s = 255;
                if (s >= thr) begin
                    mspk = mspk | (1 << i);
                    r[i] = R;
                    m[i] = (mode != 0) ? s - thr : 0;
                end else begin
                    m[i] = s;
                end
            end
        end
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < N; i++) begin
            sel = 2'(i);
            @(posedge clk);
            #1;
            check($sformatf("%s_mem%0d", tag, i), 32'(state_out), 32'(m[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spike", 32'(spike), 0);
        check("rst_state_out", 32'(state_out), 0);
    endtask

    // Runs one timestep; dup pulses step again mid-sweep, which must be ignored.
    task automatic do_step(input string tag, input logic [31:0] cur, input int thr,
                           input int b, input int mode, input bit dup);
        int cnt;
        int extra;
        @(negedge clk);
        current    = cur;
        threshold  = 8'(thr);
        beta       = 3'(b);
        reset_mode = mode[0];
        step       = 1'b1;
        @(posedge clk);
        #1;
        step       = 1'b0;
        current    = $urandom;
        threshold  = 8'($urandom_range(0, 255));
        beta       = 3'($urandom_range(0, 7));
        reset_mode = 1'($urandom_range(0, 1));
        check({tag, "_busy_rise"}, 32'(busy), 1);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            step = dup && (cnt == 2);
        end while (!done && cnt < 12);
        step = 1'b0;
        check({tag, "_done_latency"}, 32'(cnt), 32'(N + 1));
        check({tag, "_busy_at_done"}, 32'(busy), 1);
        model_step(cur, thr, b, mode);
        check({tag, "_spike"}, 32'(spike), 32'(mspk));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_busy_fall"}, 32'(busy), 0);
        if (dup) begin
            extra = 0;
            repeat (N + 4) begin
                @(posedge clk);
                #1;
                if (done || busy) extra++;
            end
            check({tag, "_no_extra_step"}, 32'(extra), 0);
        end
        readback(tag);
        check({tag, "_spike_hold"}, 32'(spike), 32'(mspk));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        model_reset();

        // 1: reset and an all-zero timestep
        do_reset();
        do_step("zero", 32'h0, 10, 0, 0, 0);

        // 2: integration and saturation on neuron 0
        do_step("int1", 32'd100, 200, 0, 0, 0);
        do_step("int2", 32'd100, 200, 0, 0, 0);
        for (int t = 0; t < 3; t++) do_step($sformatf("sat%0d", t), 32'd255, 255, 0, 0, 0);

        // 3: leak on neuron 1
        do_reset();
        do_step("leak_pre", 32'h0000_8000, 255, 0, 0, 0);
        do_step("leak_b1", 32'h0, 255, 1, 0, 0);
        do_step("leak_b3", 32'h0, 255, 3, 0, 0);

        // 4: subtract mode with refractory on neuron 2
        do_reset();
        for (int t = 0; t < 5; t++) do_step($sformatf("sub%0d", t), 32'h0046_0000, 100, 0, 1, 0);

        // 5: step while busy is ignored
        do_step("dup", 32'h0102_0304, 50, 1, 0, 1);

        // 6: asynchronous reset mid-sweep
        do_reset();
        do_step("pre_rst", 32'h3232_3232, 0, 0, 1, 0);
        @(negedge clk);
        sel  = 2'd1;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_spike", 32'(spike), 0);
        check("arst_state_out", 32'(state_out), 0);
        seen = 0;
        repeat (N + 3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("arst_no_done", 32'(seen), 0);
        model_reset();
        do_step("post_rst", 32'h1020_4080, 60, 2, 1, 0);

        // Randomised timesteps
        for (int t = 0; t < 30; t++) begin
            do_step($sformatf("rnd%0d", t), $urandom,
                    (t % 5 == 0) ? $urandom_range(0, 20) : $urandom_range(0, 255),
                    $urandom_range(0, 7), $urandom_range(0, 1), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
